// File: rtl/neopixel_pkg.sv
// Shared types and constants for the multi-channel NeoPixel register block:
// bus structs, per-channel shadow configuration, register map and channel FSM states.
package neopixel_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
  } obi_rsp_t;

  // Every field is carried at 32 bits; bits above the configured width are always 0.
  typedef struct packed {
    logic [31:0] num_pixel;
    logic [31:0] t1h;
    logic [31:0] t1l;
    logic [31:0] t0h;
    logic [31:0] t0l;
    logic [31:0] t_latch;
    logic [31:0] src_addr;
    logic [31:0] num_bytes;
  } neopixel_chan_cfg_t;

  typedef enum logic [1:0] {
    ChIdle    = 2'd0,
    ChPending = 2'd1,
    ChBusy    = 2'd2
  } chan_state_e;

  localparam int unsigned RegInfo      = 32'h00;
  localparam int unsigned RegMinFreq   = 32'h04;
  localparam int unsigned RegStart     = 32'h08;
  localparam int unsigned RegBusy      = 32'h0C;
  localparam int unsigned RegIrqStatus = 32'h10;
  localparam int unsigned RegIrqEnable = 32'h14;

  localparam int unsigned ChanBase   = 32'h40;
  localparam int unsigned ChanStride = 32'h20;

  localparam int unsigned ChNumPixel = 32'h00;
  localparam int unsigned ChT1h      = 32'h04;
  localparam int unsigned ChT1l      = 32'h08;
  localparam int unsigned ChT0h      = 32'h0C;
  localparam int unsigned ChT0l      = 32'h10;
  localparam int unsigned ChTLatch   = 32'h14;
  localparam int unsigned ChSrcAddr  = 32'h18;
  localparam int unsigned ChNumBytes = 32'h1C;

  localparam logic [31:0] MinFreqHz = 32'd3_000_000;
  localparam logic [31:0] BadData   = 32'hBADCAB1E;

  function automatic logic [31:0] be_merge(logic [31:0] old_val, logic [31:0] wdata,
                                           logic [3:0] be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/neopixel_chan_regs.sv
// One NeoPixel channel: working registers, frame-start shadow copy and the
// IDLE/PENDING/BUSY start handshake.
module neopixel_chan_regs
  import neopixel_pkg::*;
#(
  parameter int unsigned NumPixelW   = 9,
  parameter int unsigned TimingWidth = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               wr_en_i,
  input  logic [2:0]         reg_sel_i,
  input  logic [31:0]        wdata_i,
  input  logic [3:0]         be_i,
  output logic [31:0]        rdata_o,
  input  logic               start_i,
  input  logic               start_ready_i,
  input  logic               done_i,
  output neopixel_chan_cfg_t cfg_o,
  output logic               start_valid_o,
  output logic               busy_o,
  output logic               pending_o,
  output logic               done_evt_o,
  output logic               overrun_evt_o
);

  logic [NumPixelW-1:0]   num_pixel_q, num_pixel_d;
  logic [TimingWidth-1:0] t1h_q, t1h_d, t1l_q, t1l_d, t0h_q, t0h_d, t0l_q, t0l_d;
  logic [TimingWidth-1:0] t_latch_q, t_latch_d;
  logic [31:0]            src_addr_q, src_addr_d, num_bytes_q, num_bytes_d;
  logic [31:0]            merged;
  neopixel_chan_cfg_t     cfg_q, cfg_d;
  chan_state_e            state_q;
  logic                   start_valid_q, busy_q;

  always_comb begin
    case (reg_sel_i)
      3'(ChNumPixel >> 2): rdata_o = 32'(num_pixel_q);
      3'(ChT1h >> 2):      rdata_o = 32'(t1h_q);
      3'(ChT1l >> 2):      rdata_o = 32'(t1l_q);
      3'(ChT0h >> 2):      rdata_o = 32'(t0h_q);
      3'(ChT0l >> 2):      rdata_o = 32'(t0l_q);
      3'(ChTLatch >> 2):   rdata_o = 32'(t_latch_q);
      3'(ChSrcAddr >> 2):  rdata_o = src_addr_q;
      default:             rdata_o = num_bytes_q;
    endcase
  end

  // Merge against the zero-extended current value, then keep only the field's low bits.
  always_comb begin
    merged      = be_merge(rdata_o, wdata_i, be_i);
    num_pixel_d = num_pixel_q;
    t1h_d       = t1h_q;
    t1l_d       = t1l_q;
    t0h_d       = t0h_q;
    t0l_d       = t0l_q;
    t_latch_d   = t_latch_q;
    src_addr_d  = src_addr_q;
    num_bytes_d = num_bytes_q;
    if (wr_en_i) begin
      case (reg_sel_i)
        3'(ChNumPixel >> 2): num_pixel_d = merged[NumPixelW-1:0];
        3'(ChT1h >> 2):      t1h_d       = merged[TimingWidth-1:0];
        3'(ChT1l >> 2):      t1l_d       = merged[TimingWidth-1:0];
        3'(ChT0h >> 2):      t0h_d       = merged[TimingWidth-1:0];
        3'(ChT0l >> 2):      t0l_d       = merged[TimingWidth-1:0];
        3'(ChTLatch >> 2):   t_latch_d   = merged[TimingWidth-1:0];
        3'(ChSrcAddr >> 2):  src_addr_d  = merged;
        default:             num_bytes_d = merged;
      endcase
    end
  end

  always_comb begin
    cfg_d = cfg_q;
    if (state_q == ChPending && start_ready_i) begin
      cfg_d.num_pixel = 32'(num_pixel_q);
      cfg_d.t1h       = 32'(t1h_q);
      cfg_d.t1l       = 32'(t1l_q);
      cfg_d.t0h       = 32'(t0h_q);
      cfg_d.t0l       = 32'(t0l_q);
      cfg_d.t_latch   = 32'(t_latch_q);
      cfg_d.src_addr  = src_addr_q;
      cfg_d.num_bytes = num_bytes_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      num_pixel_q <= '0;
      t1h_q       <= '0;
      t1l_q       <= '0;
      t0h_q       <= '0;
      t0l_q       <= '0;
      t_latch_q   <= '0;
      src_addr_q  <= '0;
      num_bytes_q <= '0;
      cfg_q       <= '0;
    end else begin
      num_pixel_q <= num_pixel_d;
      t1h_q       <= t1h_d;
      t1l_q       <= t1l_d;
      t0h_q       <= t0h_d;
      t0l_q       <= t0l_d;
      t_latch_q   <= t_latch_d;
      src_addr_q  <= src_addr_d;
      num_bytes_q <= num_bytes_d;
      cfg_q       <= cfg_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ChIdle;
      start_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        ChIdle: if (start_i) begin
          state_q       <= ChPending;
          start_valid_q <= 1'b1;
        end
        ChPending: if (start_ready_i) begin
          state_q       <= ChBusy;
          start_valid_q <= 1'b0;
          busy_q        <= 1'b1;
        end
        ChBusy: if (done_i) begin
          state_q <= ChIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q       <= ChIdle;
          start_valid_q <= 1'b0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_o         = cfg_q;
  assign start_valid_o = start_valid_q;
  assign busy_o        = busy_q;
  assign pending_o     = (state_q == ChPending);
  assign done_evt_o    = (state_q == ChBusy) && done_i;
  assign overrun_evt_o = start_i && (state_q != ChIdle);

endmodule

// File: rtl/neopixel_multi_reg.sv
// Multi-channel NeoPixel register file: OBI decode with a one-cycle response,
// global START/BUSY/IRQ registers and one neopixel_chan_regs per strip.
module neopixel_multi_reg
  import neopixel_pkg::*;
#(
  parameter int unsigned NumChannels    = 4,
  parameter int unsigned MaxNumNeoPixel = 256,
  parameter int unsigned TimingWidth    = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  obi_req_t                             obi_req_i,
  output obi_rsp_t                             obi_rsp_o,
  output neopixel_chan_cfg_t [NumChannels-1:0] cfg_o,
  output logic [NumChannels-1:0]               start_valid_o,
  input  logic [NumChannels-1:0]               start_ready_i,
  input  logic [NumChannels-1:0]               done_i,
  output logic [NumChannels-1:0]               busy_o,
  output logic                                 irq_o
);

  localparam int unsigned ChanEnd   = ChanBase + ChanStride * NumChannels;
  localparam int unsigned BlockAw   = $clog2(ChanEnd);
  localparam int unsigned SelW      = BlockAw - 5;
  localparam int unsigned NumPixelW = $clog2(MaxNumNeoPixel + 1);

  logic [31:0]            off_w, rd, chan_rd, status, enable;
  logic [SelW-1:0]        chan_sel;
  logic                   acc, is_chan, err, wr_start, wr_stat, wr_en, chan_wr;
  logic [NumChannels-1:0] start_req, pending, done_evt, ovr_evt;
  logic [NumChannels-1:0] done_q, done_d, ovr_q, ovr_d, done_en_q, done_en_d;
  logic [NumChannels-1:0] ovr_en_q, ovr_en_d;
  logic [31:0]            chan_rdata [NumChannels];
  logic                   rvalid_q, rvalid_d, err_q, err_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [3:0]             rid_q, rid_d;
  logic                   unused_addr;

  // Only the block-local word offset matters; upper and byte-lane address bits alias.
  assign unused_addr = ^{obi_req_i.addr[31:BlockAw], obi_req_i.addr[1:0]};
  assign off_w       = 32'({obi_req_i.addr[BlockAw-1:2], 2'b00});
  assign is_chan     = (off_w >= ChanBase) && (off_w < ChanEnd);
  assign chan_sel    = SelW'((off_w - ChanBase) >> 5);
  assign acc         = obi_req_i.req;
  assign status      = 32'(done_q) | (32'(ovr_q) << 8);
  assign enable      = 32'(done_en_q) | (32'(ovr_en_q) << 8);

  always_comb begin
    chan_rd = '0;
    for (int c = 0; c < NumChannels; c++) begin
      if (chan_sel == SelW'(c)) chan_rd = chan_rdata[c];
    end
  end

  always_comb begin
    rd       = '0;
    err      = 1'b0;
    wr_start = 1'b0;
    wr_stat  = 1'b0;
    wr_en    = 1'b0;
    chan_wr  = 1'b0;
    if (is_chan) begin
      rd      = chan_rd;
      chan_wr = obi_req_i.we;
    end else begin
      case (off_w)
        RegInfo:      begin rd = {24'(MaxNumNeoPixel), 8'(NumChannels)}; err = obi_req_i.we; end
        RegMinFreq:   begin rd = MinFreqHz;           err = obi_req_i.we; end
        RegStart:     begin rd = 32'(pending);        wr_start = obi_req_i.we; end
        RegBusy:      begin rd = 32'(busy_o);         err = obi_req_i.we; end
        RegIrqStatus: begin rd = status;              wr_stat = obi_req_i.we; end
        RegIrqEnable: begin rd = enable;              wr_en = obi_req_i.we; end
        default:      begin rd = BadData;             err = 1'b1; end
      endcase
    end
    if (obi_req_i.we) rd = '0;
  end

  assign start_req = (acc && wr_start && obi_req_i.be[0]) ?
                     obi_req_i.wdata[NumChannels-1:0] : '0;

  for (genvar c = 0; c < NumChannels; c++) begin : g_chan
    neopixel_chan_regs #(
      .NumPixelW  (NumPixelW),
      .TimingWidth(TimingWidth)
    ) u_chan (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .wr_en_i      (acc && chan_wr && (chan_sel == SelW'(c))),
      .reg_sel_i    (off_w[4:2]),
      .wdata_i      (obi_req_i.wdata),
      .be_i         (obi_req_i.be),
      .rdata_o      (chan_rdata[c]),
      .start_i      (start_req[c]),
      .start_ready_i(start_ready_i[c]),
      .done_i       (done_i[c]),
      .cfg_o        (cfg_o[c]),
      .start_valid_o(start_valid_o[c]),
      .busy_o       (busy_o[c]),
      .pending_o    (pending[c]),
      .done_evt_o   (done_evt[c]),
      .overrun_evt_o(ovr_evt[c])
    );
  end

  // W1C clear is applied first so a same-cycle hardware set survives.
  always_comb begin
    done_d    = done_q;
    ovr_d     = ovr_q;
    done_en_d = done_en_q;
    ovr_en_d  = ovr_en_q;
    if (acc && wr_stat && obi_req_i.be[0]) done_d = done_d & ~obi_req_i.wdata[NumChannels-1:0];
    if (acc && wr_stat && obi_req_i.be[1]) ovr_d  = ovr_d & ~obi_req_i.wdata[8 +: NumChannels];
    done_d = done_d | done_evt;
    ovr_d  = ovr_d | ovr_evt;
    if (acc && wr_en && obi_req_i.be[0]) done_en_d = obi_req_i.wdata[NumChannels-1:0];
    if (acc && wr_en && obi_req_i.be[1]) ovr_en_d  = obi_req_i.wdata[8 +: NumChannels];
  end

  always_comb begin
    rvalid_d = acc;
    rid_d    = obi_req_i.aid;
    rdata_d  = rd;
    err_d    = acc && err;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q    <= '0;
      ovr_q     <= '0;
      done_en_q <= '0;
      ovr_en_q  <= '0;
      rvalid_q  <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      done_q    <= done_d;
      ovr_q     <= ovr_d;
      done_en_q <= done_en_d;
      ovr_en_q  <= ovr_en_d;
      rvalid_q  <= rvalid_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    obi_rsp_o        = '0;
    obi_rsp_o.gnt    = obi_req_i.req;
    obi_rsp_o.rvalid = rvalid_q;
    obi_rsp_o.rdata  = rdata_q;
    obi_rsp_o.rid    = rid_q;
    obi_rsp_o.err    = err_q;
  end

  assign irq_o = |{done_q & done_en_q, ovr_q & ovr_en_q};

endmodule

// File: tb/tb_neopixel_multi_reg.sv
// Bench for neopixel_multi_reg: directed register/handshake/IRQ/reset scenarios
// followed by random bus and handshake traffic against a register-map model.
module tb_neopixel_multi_reg;
  import neopixel_pkg::*;

  localparam int N      = 4;
  localparam int MAXPIX = 256;
  localparam int TW     = 16;
  localparam int NPW    = $clog2(MAXPIX + 1);
  localparam int BAW    = $clog2(64 + 32 * N);
  localparam logic [31:0] SMASK = ((32'd1 << N) - 1) | (((32'd1 << N) - 1) << 8);
  localparam int K_INFO = 0, K_MINF = 1, K_START = 2, K_BUSY = 3, K_STAT = 4,
                 K_EN = 5, K_CHAN = 6, K_BAD = 7;

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b0;
  obi_req_t                     req_s;
  obi_rsp_t                     rsp_s;
  neopixel_chan_cfg_t [N-1:0]   cfg;
  logic [N-1:0]                 sv, rdy, dn, bsy;
  logic                         irq;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_work [N][8];
  logic [31:0] m_shad [N][8];
  logic [N-1:0] m_pend, m_busy;
  logic [31:0] m_stat, m_en;

  neopixel_multi_reg #(.NumChannels(N), .MaxNumNeoPixel(MAXPIX), .TimingWidth(TW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .obi_req_i(req_s), .obi_rsp_o(rsp_s), .cfg_o(cfg),
    .start_valid_o(sv), .start_ready_i(rdy), .done_i(dn), .busy_o(bsy), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] fmask(int k);
    int w;
    w = (k == 0) ? NPW : (k <= 5) ? TW : 32;
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 1);
  endfunction

  function automatic logic [31:0] bmask(logic [3:0] b);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{b[i]}};
    return m;
  endfunction

  function automatic logic [31:0] cfg_field(neopixel_chan_cfg_t s, int k);
    case (k)
      0: return s.num_pixel;   1: return s.t1h;
      2: return s.t1l;         3: return s.t0h;
      4: return s.t0l;         5: return s.t_latch;
      6: return s.src_addr;    default: return s.num_bytes;
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N; c++)
      for (int k = 0; k < 8; k++) begin m_work[c][k] = '0; m_shad[c][k] = '0; end
    m_pend = '0; m_busy = '0; m_stat = '0; m_en = '0;
  endtask

  task automatic decode(input logic [31:0] a, output int kind, output int ch, output int k);
    int off;
    off  = int'(a & ((32'd1 << BAW) - 1)) & ~3;
    ch   = 0; k = 0;
    if (off >= 64 && off < 64 + 32 * N) begin
      kind = K_CHAN; ch = (off - 64) / 32; k = ((off - 64) % 32) / 4;
    end else if (off < 24) kind = off / 4;
    else kind = K_BAD;
  endtask

  // Advance one clock: predict the response and post-edge outputs, then compare.
  task automatic step();
    int kind, ch, k;
    logic [31:0] exp_rd, clr;
    logic exp_err;
    logic [N-1:0] s, set_d, set_o;
    obi_req_t r;
    #1;
    r = req_s;
    chk("gnt", 32'(rsp_s.gnt), 32'(r.req));
    decode(r.addr, kind, ch, k);
    exp_err = 1'b0; s = '0; clr = '0;
    case (kind)
      K_INFO:  begin exp_rd = MAXPIX * 256 + N; exp_err = r.we; end
      K_MINF:  begin exp_rd = 32'd3000000;      exp_err = r.we; end
      K_START: exp_rd = 32'(m_pend);
      K_BUSY:  begin exp_rd = 32'(m_busy);      exp_err = r.we; end
      K_STAT:  exp_rd = m_stat;
      K_EN:    exp_rd = m_en;
      K_CHAN:  exp_rd = m_work[ch][k];
      default: begin exp_rd = 32'hBADCAB1E;     exp_err = 1'b1; end
    endcase
    if (r.req && r.we && kind == K_START && r.be[0]) s = r.wdata[N-1:0];
    if (r.req && r.we && kind == K_STAT) clr = r.wdata & bmask(r.be) & SMASK;
    set_d = '0; set_o = '0;
    for (int c = 0; c < N; c++) begin
      if ((m_pend[c] || m_busy[c]) && s[c]) set_o[c] = 1'b1;
      if (m_busy[c] && dn[c]) begin
        set_d[c] = 1'b1; m_busy[c] = 1'b0;
      end else if (m_pend[c] && rdy[c]) begin
        m_pend[c] = 1'b0; m_busy[c] = 1'b1; m_shad[c] = m_work[c];
      end else if (!m_pend[c] && !m_busy[c] && s[c]) m_pend[c] = 1'b1;
    end
    m_stat = (m_stat & ~clr) | 32'(set_d) | (32'(set_o) << 8);
    if (r.req && r.we) begin
      if (kind == K_EN)
        m_en = ((m_en & ~bmask(r.be)) | (r.wdata & bmask(r.be))) & SMASK;
      if (kind == K_CHAN)
        m_work[ch][k] = ((m_work[ch][k] & ~bmask(r.be)) | (r.wdata & bmask(r.be))) & fmask(k);
    end
    @(posedge clk);
    #1;
    chk("rvalid", 32'(rsp_s.rvalid), 32'(r.req));
    if (r.req) begin
      chk("err", 32'(rsp_s.err), 32'(exp_err));
      chk("rid", 32'(rsp_s.rid), 32'(r.aid));
      if (!r.we) chk("rdata", rsp_s.rdata, exp_rd);
    end
    chk("start_valid", 32'(sv), 32'(m_pend));
    chk("busy", 32'(bsy), 32'(m_busy));
    chk("irq", 32'(irq), 32'(|(m_stat & m_en)));
    for (int c = 0; c < N; c++)
      for (int f = 0; f < 8; f++) chk("cfg", cfg_field(cfg[c], f), m_shad[c][f]);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    req_s.req = 1'b1; req_s.we = 1'b1; req_s.addr = a; req_s.wdata = d; req_s.be = b;
    req_s.aid = 4'($urandom);
    step();
    req_s.req = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic e);
    req_s.req = 1'b1; req_s.we = 1'b0; req_s.addr = a; req_s.wdata = '0; req_s.be = 4'hF;
    req_s.aid = 4'($urandom);
    step();
    d = rsp_s.rdata; e = rsp_s.err;
    req_s.req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    logic [31:0] gaddr [14];
    gaddr = '{32'h00, 32'h04, 32'h08, 32'h08, 32'h0C, 32'h10, 32'h10, 32'h14,
              32'h18, 32'h20, 32'h3C, 32'hC0, 32'hFC, 32'h108};
    req_s = '0; rdy = '0; dn = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sv", 32'(sv), 0);
    chk("rst_busy", 32'(bsy), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_rvalid", 32'(rsp_s.rvalid), 0);
    chk("rst_err", 32'(rsp_s.err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    wr(32'h64, 32'h12345, 4'hF);
    rd(32'h64, d, e);
    chk("t1h_trunc", d, 32'h2345);
    chk("t1h_err", 32'(e), 0);
    wr(32'h64, 32'hFF, 4'h1);
    rd(32'h64, d, e);
    chk("t1h_be", d, 32'h23FF);

    wr(32'h40, 32'd10, 4'hF);
    wr(32'h08, 32'h1, 4'hF);
    chk("pend_sv1", 32'(sv[0]), 1);
    idle(1);
    chk("pend_sv2", 32'(sv[0]), 1);
    idle(1);
    chk("pend_sv3", 32'(sv[0]), 1);
    chk("pend_cfg", cfg[0].num_pixel, 0);
    rdy = 4'b0001;
    idle(1);
    rdy = '0;
    chk("go_busy", 32'(bsy[0]), 1);
    chk("go_cfg", cfg[0].num_pixel, 10);

    wr(32'h40, 32'd20, 4'hF);
    chk("shadow_hold", cfg[0].num_pixel, 10);
    wr(32'h08, 32'h1, 4'hF);
    chk("ovr_no_sv", 32'(sv[0]), 0);
    rd(32'h10, d, e);
    chk("ovr_bit", 32'(d[8]), 1);

    wr(32'h14, 32'h1, 4'hF);
    dn = 4'b0001;
    idle(1);
    dn = '0;
    chk("irq_set", 32'(irq), 1);
    wr(32'h10, 32'h1, 4'hF);
    chk("irq_clr", 32'(irq), 0);
    wr(32'h08, 32'h1, 4'hF);
    rdy = 4'b0001;
    idle(1);
    rdy = '0;
    dn = 4'b0001;
    wr(32'h10, 32'h1, 4'hF);
    dn = '0;
    rd(32'h10, d, e);
    chk("set_wins", 32'(d[0]), 1);

    rd(32'h20, d, e);
    chk("unmap_err", 32'(e), 1);
    chk("unmap_data", d, 32'hBADCAB1E);
    wr(32'h00, 32'hFFFF_FFFF, 4'hF);
    chk("ro_wr_err", 32'(rsp_s.err), 1);
    rd(32'hC0, d, e);
    chk("past_err", 32'(e), 1);
    chk("past_data", d, 32'hBADCAB1E);
    rd(32'h00, d, e);
    chk("info", d, 32'h0001_0004);

    wr(32'h08, 32'hC, 4'hF);
    rdy = 4'b1000;
    idle(1);
    rdy = '0;
    chk("ch2_pend", 32'(sv[2]), 1);
    chk("ch3_busy", 32'(bsy[3]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sv", 32'(sv), 0);
    chk("arst_busy", 32'(bsy), 0);
    chk("arst_irq", 32'(irq), 0);
    chk("arst_rvalid", 32'(rsp_s.rvalid), 0);
    chk("arst_cfg", cfg[0].num_pixel, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    rd(32'h10, d, e); chk("post_stat", d, 0);
    rd(32'h14, d, e); chk("post_en", d, 0);
    rd(32'h40, d, e); chk("post_np", d, 0);
    rd(32'h64, d, e); chk("post_t1h", d, 0);

    for (int i = 0; i < 3000; i++) begin
      req_s.req = ($urandom_range(0, 3) != 0);
      req_s.we  = $urandom_range(0, 1);
      if ($urandom_range(0, 9) < 4)
        req_s.addr = 32'h40 + 32'h20 * $urandom_range(0, N - 1) + 4 * $urandom_range(0, 7);
      else
        req_s.addr = gaddr[$urandom_range(0, 13)];
      if ($urandom_range(0, 4) == 0) req_s.addr = req_s.addr | ($urandom << BAW);
      req_s.be    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      req_s.wdata = $urandom;
      if ((req_s.addr & ((32'd1 << BAW) - 1)) == 32'h08) req_s.wdata = $urandom_range(0, 15);
      req_s.aid = 4'($urandom);
      rdy = N'($urandom);
      for (int c = 0; c < N; c++) dn[c] = ($urandom_range(0, 3) == 0);
      step();
    end
    req_s.req = 1'b0; rdy = '0; dn = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
